// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the MIPS-subset datapath: sequences fetch/decode/execute/mem/writeback
// and handshakes with stalling instruction and data memories.
module multicycle_controller #(
    parameter int unsigned COUNT_W    = 32,
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [31:0]        instruction,
    input  logic               zero,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               imem_req,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               alu_src,
    output logic               ext_sign,
    output logic [2:0]         alu_command,
    output logic               dmem_req,
    output logic               dmem_write,
    output logic               illegal,
    output logic               bus_error,
    output logic [2:0]         state_out,
    output logic [COUNT_W-1:0] instr_count
);

    localparam int unsigned WaitW = $clog2(WAIT_LIMIT + 1);

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpXori  = 6'h0e;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2b;
    localparam logic [5:0] FnAdd   = 6'h20;
    localparam logic [5:0] FnSub   = 6'h22;
    localparam logic [5:0] FnSlt   = 6'h2a;
    localparam logic [5:0] FnJr    = 6'h08;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StFetch     = 3'd1,
        StDecode    = 3'd2,
        StExecute   = 3'd3,
        StMem       = 3'd4,
        StWriteback = 3'd5,
        StHalt      = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic               illegal_q, illegal_d;
    logic               bus_error_q, bus_error_d;
    logic [COUNT_W-1:0] count_q;
    logic               retire;

    logic [5:0] opcode, funct;
    logic       is_rtype, r_alu, is_jr, wait_expired;
    logic       alu_src_x, ext_sign_x;
    logic [2:0] alu_cmd_x;
    logic       unused_ir;

    assign opcode       = instruction[31:26];
    assign funct        = instruction[5:0];
    assign unused_ir    = ^instruction[25:6];
    assign is_rtype     = (opcode == OpRtype);
    assign r_alu        = is_rtype && (funct == FnAdd || funct == FnSub || funct == FnSlt);
    assign is_jr        = is_rtype && (funct == FnJr);
    assign wait_expired = (wait_q == WaitW'(WAIT_LIMIT - 1));

    // ALU setup is shared by EXECUTE, MEM and WRITEBACK so the result stays stable.
    always_comb begin
        alu_src_x  = 1'b0;
        ext_sign_x = 1'b0;
        alu_cmd_x  = 3'd0;
        unique case (opcode)
            OpRtype: begin
                if (funct == FnSub)      alu_cmd_x = 3'd1;
                else if (funct == FnSlt) alu_cmd_x = 3'd3;
            end
            OpAddi, OpLw, OpSw: begin
                alu_src_x  = 1'b1;
                ext_sign_x = 1'b1;
            end
            OpXori: begin
                alu_src_x = 1'b1;
                alu_cmd_x = 3'd2;
            end
            OpBne:   alu_cmd_x = 3'd1;
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = '0;
        illegal_d   = illegal_q;
        bus_error_d = bus_error_q;
        retire      = 1'b0;
        case (state_q)
            StIdle: if (enable) state_d = StFetch;
            StFetch: begin
                if (imem_ready) begin
                    state_d = StDecode;
                end else if (wait_expired) begin
                    bus_error_d = 1'b1;
                    state_d     = StHalt;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StDecode: begin
                if (opcode == OpJ || opcode == OpJal || is_jr) begin
                    retire = 1'b1;
                end else if (r_alu || opcode == OpLw || opcode == OpSw || opcode == OpAddi ||
                             opcode == OpXori || opcode == OpBne) begin
                    state_d = StExecute;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = StHalt;
                end
            end
            StExecute: begin
                if (opcode == OpBne)                      retire  = 1'b1;
                else if (opcode == OpLw || opcode == OpSw) state_d = StMem;
                else                                      state_d = StWriteback;
            end
            StMem: begin
                if (dmem_ready) begin
                    if (opcode == OpSw) retire  = 1'b1;
                    else                state_d = StWriteback;
                end else if (wait_expired) begin
                    bus_error_d = 1'b1;
                    state_d     = StHalt;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StWriteback: retire = 1'b1;
            StHalt:      state_d = StHalt;
            default:     state_d = StIdle;
        endcase
        // enable is only looked at when a new fetch would start.
        if (retire) state_d = enable ? StFetch : StIdle;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            wait_q      <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            illegal_q   <= illegal_d;
            bus_error_q <= bus_error_d;
            if (retire) count_q <= count_q + COUNT_W'(1);
        end
    end

    always_comb begin
        imem_req    = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'd0;
        reg_write   = 1'b0;
        reg_dst     = 2'd0;
        mem_to_reg  = 2'd0;
        alu_src     = 1'b0;
        ext_sign    = 1'b0;
        alu_command = 3'd0;
        dmem_req    = 1'b0;
        dmem_write  = 1'b0;
        case (state_q)
            StFetch: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
                pc_write = imem_ready;
            end
            StDecode: begin
                if (opcode == OpJ || opcode == OpJal) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                end else if (is_jr) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd3;
                end
                if (opcode == OpJal) begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'd2;
                    mem_to_reg = 2'd2;
                end
            end
            StExecute: begin
                alu_src     = alu_src_x;
                ext_sign    = ext_sign_x;
                alu_command = alu_cmd_x;
                if (opcode == OpBne && !zero) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd1;
                end
            end
            StMem: begin
                alu_src     = alu_src_x;
                ext_sign    = ext_sign_x;
                alu_command = alu_cmd_x;
                dmem_req    = 1'b1;
                dmem_write  = (opcode == OpSw);
            end
            StWriteback: begin
                alu_src     = alu_src_x;
                ext_sign    = ext_sign_x;
                alu_command = alu_cmd_x;
                reg_write   = 1'b1;
                reg_dst     = is_rtype ? 2'd1 : 2'd0;
                mem_to_reg  = (opcode == OpLw) ? 2'd1 : 2'd0;
            end
            default: ;
        endcase
    end

    assign illegal     = illegal_q;
    assign bus_error   = bus_error_q;
    assign state_out   = state_q;
    assign instr_count = count_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequences the MIPS-subset datapath (ifetch, register file, ALU, data memory) as a multi-cycle machine: FETCH, DECODE, EXECUTE, MEM, WRITEBACK.
- Drives every datapath control line and handshakes with instruction and data memories that may stall.
- Sits beside the datapath in the cpu top level. It replaces the single-cycle control block.

Parameters:
- COUNT_W, 32, width of retired-instruction counter.
- WAIT_LIMIT, 16, max cycles a memory request may wait for ready before bus_error.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous reset, active low.
- enable  in  1  run request.
- instruction  in  32  current IR contents (opcode [31:26], funct [5:0]).
- zero  in  1  ALU zero flag.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  latch instruction register.
- pc_write  out  1  update PC.
- pc_src  out  2  0=PC+4, 1=branch target, 2=jump target, 3=Da.
- reg_write  out  1  register file write enable.
- reg_dst  out  2  0=Rt, 1=Rd, 2=$31.
- mem_to_reg  out  2  0=ALU result, 1=memory data, 2=PC+4.
- alu_src  out  1  0=Db, 1=extended immediate.
- ext_sign  out  1  1=sign-extend imm, 0=zero-extend.
- alu_command  out  3  0=ADD, 1=SUB, 2=XOR, 3=SLT, 4=AND, 5=NAND, 6=NOR, 7=OR.
- dmem_req  out  1  data memory request.
- dmem_write  out  1  1=store, 0=load (valid only with dmem_req).
- illegal  out  1  sticky, unsupported instruction decoded.
- bus_error  out  1  sticky, memory wait exceeded WAIT_LIMIT.
- state_out  out  3  current state encoding.
- instr_count  out  COUNT_W  retired instructions.

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, HALT=6.
- Control outputs are combinational in state and IR fields. Every output is 0 in IDLE and HALT.
- Reset (async, reset_n low):
  - state=IDLE; illegal, bus_error, instr_count and wait counter cleared.
  - Asserted mid-instruction: all outputs drop immediately and no partial write completes.
- IDLE -> FETCH when enable=1.
- FETCH:
  - imem_req=1 every cycle.
  - When imem_ready=1: ir_write=1, pc_write=1, pc_src=0, go to DECODE. Otherwise stay.
  - enable is sampled only on FETCH entry; enable=0 at that point returns to IDLE, so the current instruction always finishes.
- DECODE by opcode/funct:
  - J (0x02): pc_write, pc_src=2 -> FETCH, retire.
  - JAL (0x03): additionally reg_write=1, reg_dst=2, mem_to_reg=2.
  - JR (R-type funct 0x08): pc_write, pc_src=3 -> FETCH, retire.
  - Other supported instructions -> EXECUTE.
  - Unsupported opcode/funct: illegal=1 -> HALT.
- Supported set: R-type ADD 0x20, SUB 0x22, SLT 0x2a, JR 0x08; LW 0x23, SW 0x2b, ADDI 0x08, XORI 0x0e, BNE 0x05, J, JAL.
- EXECUTE:
  - R-type: alu_src=0; command ADD/SUB/SLT by funct -> WRITEBACK.
  - ADDI, LW, SW: alu_src=1, ext_sign=1, ADD.
    - ADDI -> WRITEBACK; LW, SW -> MEM.
  - XORI: alu_src=1, ext_sign=0, XOR -> WRITEBACK.
  - BNE: alu_src=0, SUB.
    - zero=0: pc_write=1, pc_src=1.
    - Either way -> FETCH, retire.
- MEM:
  - dmem_req=1, dmem_write=1 for SW, 0 for LW.
  - Hold until dmem_ready=1; then SW -> FETCH (retire), LW -> WRITEBACK.
- WRITEBACK:
  - reg_write=1.
  - reg_dst: 1 for R-type, 0 for ADDI/XORI/LW.
  - mem_to_reg: 1 for LW, else 0.
  - Keep the EXECUTE alu_src/alu_command so the ALU result stays stable.
  - -> FETCH, retire.
- Retire: instr_count increments by 1 on the retiring transition, wrapping modulo 2^COUNT_W.
- Wait counter:
  - Counts consecutive FETCH or MEM cycles with ready=0; clears on ready=1 or on state change.
  - Reaching WAIT_LIMIT: bus_error=1 -> HALT, with no write performed.
  - If ready=1 arrives on the limit cycle, ready wins.
- HALT: only reset exits.
- Minimum latencies with ready on the first cycle:
  - J/JAL/JR: 2 cycles.
  - BNE: 3 cycles.
  - R/ADDI/XORI/SW: 4 cycles.
  - LW: 5 cycles.

Test Plan:
- Reset, enable=1, IR=ADD ($3=$1+$2, 0x00221820), ready=1 -> state 1,2,3,5,1; reg_write=1 in cycle 4 with reg_dst=1, alu_command=0; instr_count=1.
- LW 0x8C220004 with dmem_ready delayed 3 cycles -> MEM held 4 cycles, dmem_req=1, dmem_write=0; WRITEBACK mem_to_reg=1, reg_dst=0; total 8 cycles.
- BNE with zero=0 then zero=1 -> first: pc_write=1, pc_src=1 in EXECUTE; second: pc_write=0; both return to FETCH and count +1.
- JAL 0x0C000010 -> DECODE: pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2; 2 cycles total.
- Opcode 0x3F -> illegal=1, state=6, all controls 0, stays after enable toggles; reset_n low clears to IDLE.
- imem_ready held 0 for WAIT_LIMIT=16 cycles -> bus_error=1, HALT. Separately, reset_n low during MEM -> dmem_req drops the same cycle and no reg_write occurs.
